// File: rtl/scan_decoder.sv
// Select decoder with direct and auto-scan modes.
// Drives a registered one-hot (or one-cold) select, the current index and a wrap pulse.
module scan_decoder #(
  parameter int SEL_WIDTH  = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                        Clock,
  input  logic                        Reset_n,
  input  logic                        Enable,
  input  logic                        Mode,
  input  logic [SEL_WIDTH-1:0]        Decoder_Input,
  input  logic [SEL_WIDTH-1:0]        Last_Index,
  output logic [(1<<SEL_WIDTH)-1:0]   Decoder_Output,
  output logic [SEL_WIDTH-1:0]        Index,
  output logic                        Wrap
);

  localparam int OUT_WIDTH = 1 << SEL_WIDTH;
  localparam int CNT_WIDTH = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL - 1);
  localparam logic [OUT_WIDTH-1:0] INACTIVE   = {OUT_WIDTH{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [SEL_WIDTH-1:0]   index_reg, index_next;
  logic [CNT_WIDTH-1:0]   dwell_reg, dwell_next;
  logic                   wrap_reg, wrap_next;
  logic [OUT_WIDTH-1:0]   out_reg, out_next, onehot_next;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      index_reg <= '0;
      dwell_reg <= '0;
      wrap_reg  <= 1'b0;
      out_reg   <= INACTIVE;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      dwell_reg <= dwell_next;
      wrap_reg  <= wrap_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    index_next = index_reg;
    dwell_next = '0;
    wrap_next  = 1'b0;
    if (!Enable) begin
      state_next = IDLE;
    end else if (!Mode) begin
      state_next = DIRECT;
      index_next = Decoder_Input;
    end else begin
      state_next = SCAN;
      if (state_reg != SCAN) begin
        // Coming from DIRECT restarts the sweep; coming from IDLE resumes it.
        if (state_reg == DIRECT) begin
          index_next = '0;
        end
      end else if (dwell_reg == DWELL_LAST) begin
        // A ">=" wrap also catches Last_Index lowered beneath the live index.
        if (index_reg < Last_Index) begin
          index_next = index_reg + 1'b1;
        end else begin
          index_next = '0;
          wrap_next  = 1'b1;
        end
      end else begin
        dwell_next = dwell_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_decode
      assign onehot_next[gi] = (state_next != IDLE) && (index_next == SEL_WIDTH'(gi));
    end
  endgenerate

  assign out_next       = ACTIVE_LOW ? ~onehot_next : onehot_next;
  assign Decoder_Output = out_reg;
  assign Index          = index_reg;
  assign Wrap           = wrap_reg;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: three parameterisations checked each cycle against a
// rule-level model, plus directed literal expectations.
module tb_scan_decoder;

  logic       clk;
  logic       rst_n;
  logic       en, mode;
  logic [1:0] din, last;
  logic       en_c, mode_c;
  logic [2:0] din_c, last_c;

  logic [3:0] out_a, out_b;
  logic [1:0] idx_a, idx_b;
  logic       wrap_a, wrap_b;
  logic [7:0] out_c;
  logic [2:0] idx_c;
  logic       wrap_c;

  int tests = 0;
  int fails = 0;

  scan_decoder #(.SEL_WIDTH(2), .DWELL(4), .ACTIVE_LOW(1'b0)) dut_a (
    .Clock(clk), .Reset_n(rst_n), .Enable(en), .Mode(mode),
    .Decoder_Input(din), .Last_Index(last),
    .Decoder_Output(out_a), .Index(idx_a), .Wrap(wrap_a)
  );

  scan_decoder #(.SEL_WIDTH(2), .DWELL(1), .ACTIVE_LOW(1'b0)) dut_b (
    .Clock(clk), .Reset_n(rst_n), .Enable(en), .Mode(mode),
    .Decoder_Input(din), .Last_Index(last),
    .Decoder_Output(out_b), .Index(idx_b), .Wrap(wrap_b)
  );

  scan_decoder #(.SEL_WIDTH(3), .DWELL(2), .ACTIVE_LOW(1'b1)) dut_c (
    .Clock(clk), .Reset_n(rst_n), .Enable(en_c), .Mode(mode_c),
    .Decoder_Input(din_c), .Last_Index(last_c),
    .Decoder_Output(out_c), .Index(idx_c), .Wrap(wrap_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: st 0=idle 1=direct 2=scan; shown = cycles the current index has been on display.
  typedef struct {
    int st;
    int idx;
    int shown;
    bit wrap;
  } m_t;

  localparam m_t M_RESET = '{st: 0, idx: 0, shown: 0, wrap: 1'b0};

  m_t ma = M_RESET;
  m_t mb = M_RESET;
  m_t mc = M_RESET;

  function automatic m_t step(m_t m, bit e, bit md, int d, int lst, int dwell);
    m_t r;
    r = m;
    r.wrap = 1'b0;
    if (!e) begin
      r.st = 0;
    end else if (!md) begin
      r.st  = 1;
      r.idx = d;
    end else if (m.st != 2) begin
      r.st    = 2;
      r.shown = 1;
      if (m.st == 1) r.idx = 0;
    end else if (m.shown < dwell) begin
      r.shown = m.shown + 1;
    end else begin
      r.shown = 1;
      if (m.idx < lst) r.idx = m.idx + 1;
      else begin
        r.idx  = 0;
        r.wrap = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_out(m_t m, int n, bit al);
    logic [31:0] v;
    logic [31:0] mask;
    v    = (m.st == 0) ? 32'd0 : (32'd1 << m.idx);
    mask = (32'd1 << (1 << n)) - 32'd1;
    if (al) v = ~v & mask;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = M_RESET;
      mb = M_RESET;
      mc = M_RESET;
    end else begin
      ma = step(ma, en, mode, int'(din), int'(last), 4);
      mb = step(mb, en, mode, int'(din), int'(last), 1);
      mc = step(mc, en_c, mode_c, int'(din_c), int'(last_c), 2);
    end
  end

  always @(negedge clk) begin
    chk("a_out",  32'(out_a),  exp_out(ma, 2, 1'b0));
    chk("a_idx",  32'(idx_a),  32'(ma.idx));
    chk("a_wrap", 32'(wrap_a), 32'(ma.wrap));
    chk("b_out",  32'(out_b),  exp_out(mb, 2, 1'b0));
    chk("b_idx",  32'(idx_b),  32'(mb.idx));
    chk("b_wrap", 32'(wrap_b), 32'(mb.wrap));
    chk("c_out",  32'(out_c),  exp_out(mc, 3, 1'b1));
    chk("c_idx",  32'(idx_c),  32'(mc.idx));
    chk("c_wrap", 32'(wrap_c), 32'(mc.wrap));
  end

  logic [3:0] lit_onehot [4];

  initial begin
    lit_onehot[0] = 4'b0001;
    lit_onehot[1] = 4'b0010;
    lit_onehot[2] = 4'b0100;
    lit_onehot[3] = 4'b1000;

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; din = 2'd0; last = 2'd0;
    en_c = 1'b0; mode_c = 1'b0; din_c = 3'd0; last_c = 3'd0;

    // Reset state
    @(negedge clk);
    chk("rst_a_out",  32'(out_a),  32'h0);
    chk("rst_a_idx",  32'(idx_a),  32'h0);
    chk("rst_a_wrap", 32'(wrap_a), 32'h0);
    chk("rst_c_out",  32'(out_c),  32'hFF);
    $display("[TB] reset checked");
    rst_n = 1'b1;

    // Direct decode, one-cycle latency
    en = 1'b1; mode = 1'b0;
    en_c = 1'b1; mode_c = 1'b0; din_c = 3'd5;
    for (int k = 0; k < 4; k++) begin
      din = 2'(k);
      @(negedge clk);
      chk("direct_a_out", 32'(out_a), 32'(lit_onehot[k]));
      $display("[TB] direct din=%0d out=%b", k, out_a);
      if (k == 0) begin
        chk("direct_c_out", 32'(out_c), 32'b11011111);
        en_c = 1'b0;
      end
      if (k == 1) chk("idle_c_out", 32'(out_c), 32'hFF);
    end

    // Scan DWELL=4 Last_Index=3, entered from DIRECT
    mode = 1'b1; last = 2'd3;
    en_c = 1'b1; mode_c = 1'b1; last_c = 3'd7;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      chk("scan_a_idx",  32'(idx_a),  32'((c / 4) % 4));
      chk("scan_a_wrap", 32'(wrap_a), (c == 16) ? 32'd1 : 32'd0);
      $display("[TB] scan c=%0d idx=%0d wrap=%0d", c, idx_a, wrap_a);
    end

    // Pause at index 2 then resume with a full dwell
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pause_a_out", 32'(out_a), 32'h0);
      chk("pause_a_idx", 32'(idx_a), 32'd2);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("resume_a_idx", 32'(idx_a), 32'd2);
      chk("resume_a_out", 32'(out_a), 32'b0100);
    end
    @(negedge clk);
    chk("resume_a_next", 32'(idx_a), 32'd3);
    $display("[TB] pause/resume idx=%0d", idx_a);

    // DWELL=1: Last_Index lowered beneath a held index 3
    mode = 1'b0; din = 2'd3;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; mode = 1'b1; last = 2'd2;
    @(negedge clk);
    chk("b_entry_idx",  32'(idx_b),  32'd3);
    chk("b_entry_wrap", 32'(wrap_b), 32'd0);
    last = 2'd1;
    @(negedge clk);
    chk("b_lower_idx",  32'(idx_b),  32'd0);
    chk("b_lower_wrap", 32'(wrap_b), 32'd1);
    @(negedge clk);
    chk("b_step_idx",  32'(idx_b),  32'd1);
    chk("b_step_wrap", 32'(wrap_b), 32'd0);
    $display("[TB] dwell1 lowered last idx=%0d", idx_b);

    // Last_Index=0: index pinned at 0, wrap every DWELL cycles
    last = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("b_last0_idx",  32'(idx_b),  32'd0);
      chk("b_last0_wrap", 32'(wrap_b), 32'd1);
    end
    $display("[TB] last_index=0 run done");

    // Asynchronous reset mid-scan at index 1
    mode = 1'b0; din = 2'd0;
    @(negedge clk);
    mode = 1'b1; last = 2'd3;
    for (int c = 0; c < 6; c++) @(negedge clk);
    chk("pre_rst_a_idx", 32'(idx_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a_out",  32'(out_a),  32'h0);
    chk("async_rst_a_idx",  32'(idx_a),  32'h0);
    chk("async_rst_a_wrap", 32'(wrap_a), 32'h0);
    chk("async_rst_c_out",  32'(out_c),  32'hFF);
    $display("[TB] async reset out=%b idx=%0d", out_a, idx_a);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_a_out", 32'(out_a), 32'b0001);
    chk("post_rst_a_idx", 32'(idx_a), 32'd0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    $display("[TB] post-reset scan idx=%0d", idx_a);

    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
